// File: rtl/ahb_defs.sv
// ahb_defs: shared AHB htrans/hresp codes and arbiter state encoding
package ahb_defs;
  localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11;
  localparam logic [1:0] HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01, HRESP_RETRY = 2'b10, HRESP_SPLIT = 2'b11;
  localparam logic [1:0] ST_PARK = 2'd0, ST_OWN = 2'd1, ST_LOCKED = 2'd2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner; search starts at last+1, the last owner is considered last
//   req: request vector, last: previous owner, win: winner index, valid: any request
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [1:0]   win,
  output logic         valid
);
  always_comb begin
    win = last;
    for (int i = N; i >= 1; i--) win = req[(int'(last) + i) % N] ? 2'((int'(last) + i) % N) : win;
  end
  assign valid = |req;
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with parking, locked transfers and beat-count pre-emption
//   in : hclk, hresetn, hbusreq, hlock, htrans (owner's), hready
//   out: hgrant (one-hot), hmaster (address phase), hmaster_d (data phase), hmastlock
module ahb_arbiter
  import ahb_defs::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 16
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [1:0]             hmaster,
  output logic [1:0]             hmaster_d,
  output logic                   hmastlock
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [1:0] DEF = 2'(DEFAULT_MASTER);
  logic [1:0] state, state_n, hmaster_n, win, pick, pick_state;
  logic [CW-1:0] cnt, cnt_n;
  logic valid, beat, others, cnt_hit, go_lock, handover, release_lock;
  rr_pick #(.N(NUM_MASTERS)) u_rr (.req(hbusreq), .last(hmaster), .win(win), .valid(valid));
  assign beat = htrans[1];
  assign others = |(hbusreq & ~hgrant);
  // include the beat completing this cycle so the owner gets exactly MAX_BEATS beats
  assign cnt_hit = int'(cnt) + int'(beat) >= MAX_BEATS;
  assign go_lock = hlock[hmaster] && htrans == HT_NONSEQ;
  assign handover = htrans != HT_BUSY && (!hbusreq[hmaster] || (others && (htrans == HT_IDLE || cnt_hit)));
  assign release_lock = !hlock[hmaster] && (htrans == HT_IDLE || htrans == HT_NONSEQ);
  assign pick = valid ? win : DEF;
  assign pick_state = valid ? ST_OWN : ST_PARK;
  always_comb begin
    state_n = state;
    hmaster_n = hmaster;
    if (state == ST_PARK) begin
      state_n = valid ? ST_OWN : ST_PARK;
      hmaster_n = pick;
    end else if (state == ST_OWN) begin
      state_n = go_lock ? ST_LOCKED : handover ? pick_state : state;
      hmaster_n = !go_lock && handover ? pick : hmaster;
    end else if (release_lock) begin
      state_n = pick_state;
      hmaster_n = pick;
    end
    cnt_n = hmaster_n != hmaster ? '0 : (beat && int'(cnt) < MAX_BEATS) ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_PARK;
      hmaster <= DEF;
      hmaster_d <= DEF;
      hgrant <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmastlock <= 1'b0;
      cnt <= '0;
    end else if (hready) begin
      state <= state_n;
      hmaster <= hmaster_n;
      hmaster_d <= hmaster;
      hgrant <= NUM_MASTERS'(1) << hmaster_n;
      hmastlock <= state_n == ST_LOCKED;
      cnt <= cnt_n;
    end
  end
endmodule
